minimig_autoconfig_chain: RTL and testbench

MINIMIG_AUTOCONFIG_CHAIN -- requirements
Module: minimig_autoconfig_chain

---
 rtl/minimig_autoconfig_chain.sv | 158 +++++++++++++++
 tb/tb_minimig_autoconfig_chain.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/minimig_autoconfig_chain.sv
// Autoconfig chain for a Minimig-style Amiga core.
// Walks a list of up to eight Zorro II / Zorro III boards, presents one board at a time in
// the autoconfig register window and captures the base address the OS writes back.
// Optional feature: define MINIMIG_AUTOCONFIG_SHUTUP_EN to honour the shut-up register (0x4C),
// which skips the presented board without assigning it an address.
module minimig_autoconfig_chain #(
   parameter int unsigned NUM_BOARDS   = 4,
   parameter logic [15:0] MANUFACTURER = 16'h0A1C
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clk7_en,
   input  logic [7:0]                address_in,
   input  logic [15:0]               data_in,
   input  logic                      rd,
   input  logic                      hwr,
   input  logic                      lwr,
   input  logic                      sel,
   input  logic                      m68020,
   input  logic [NUM_BOARDS-1:0]     board_enable,
   input  logic [NUM_BOARDS-1:0]     board_z3,
   input  logic [4*NUM_BOARDS-1:0]   board_size,
   output logic [15:0]               data_out,
   output logic [NUM_BOARDS-1:0]     board_configured,
   output logic [16*NUM_BOARDS-1:0]  board_base,
   output logic                      autoconfig_done
);

   // Register offsets as seen on address_in (offset >> 1).
   localparam logic [7:0] AddrType    = 8'h00;  // 0x00
   localparam logic [7:0] AddrSize    = 8'h01;  // 0x02
   localparam logic [7:0] AddrProduct = 8'h03;  // 0x06
   localparam logic [7:0] AddrMfg0    = 8'h08;  // 0x10
   localparam logic [7:0] AddrMfg1    = 8'h09;  // 0x12
   localparam logic [7:0] AddrMfg2    = 8'h0A;  // 0x14
   localparam logic [7:0] AddrMfg3    = 8'h0B;  // 0x16
   localparam logic [7:0] AddrBaseZ3  = 8'h22;  // 0x44
   localparam logic [7:0] AddrBaseZ2  = 8'h24;  // 0x48
`ifdef MINIMIG_AUTOCONFIG_SHUTUP_EN
   localparam logic [7:0] AddrShutup  = 8'h26;  // 0x4C
`endif

   localparam logic [3:0] LastIdx = 4'(NUM_BOARDS - 1);
   localparam logic [3:0] EndIdx  = 4'(NUM_BOARDS);

   typedef enum logic [1:0] {StScan, StPresent, StDone} state_e;

   state_e      state_q;
   logic [3:0]  idx_q;

   logic        cur_enable;
   logic        cur_z3;
   logic [3:0]  cur_size;
   logic        eligible;
   logic        bus_wr;
   logic        wr_base;
   logic [3:0]  nib;
   logic [15:0] rd_data;

   // The read strobe carries no information here: data_out tracks sel/address every clock.
   logic        unused_rd;
   assign unused_rd = rd;

   // Pick out the attributes of the board currently addressed by idx (zero once past the end).
   always_comb begin
      cur_enable = 1'b0;
      cur_z3     = 1'b0;
      cur_size   = 4'h0;
      for (int i = 0; i < int'(NUM_BOARDS); i++) begin
         if (idx_q == 4'(i)) begin
            cur_enable = board_enable[i];
            cur_z3     = board_z3[i];
            cur_size   = board_size[4*i +: 4];
         end
      end
   end

   // Eligibility and write decode for the presented board.
   always_comb begin
      eligible = cur_enable & (~cur_z3 | m68020);
      bus_wr   = clk7_en & sel & (hwr | lwr);
      // Each board type only accepts its own base-address register.
      wr_base  = bus_wr & ((~cur_z3 & (address_in == AddrBaseZ2)) |
                           ( cur_z3 & (address_in == AddrBaseZ3)));
   end

   // Read-data nibble for the autoconfig window; everything reads back as F outside PRESENT.
   always_comb begin
      nib = 4'hF;
      if (state_q == StPresent) begin
         case (address_in)
            AddrType:    nib = cur_z3 ? 4'hA : 4'hE;
            AddrSize:    nib = cur_size;
            AddrProduct: nib = ~idx_q;
            AddrMfg0:    nib = ~MANUFACTURER[15:12];
            AddrMfg1:    nib = ~MANUFACTURER[11:8];
            AddrMfg2:    nib = ~MANUFACTURER[7:4];
            AddrMfg3:    nib = ~MANUFACTURER[3:0];
            default:     nib = 4'hF;
         endcase
      end
      rd_data = sel ? {nib, 12'hFFF} : 16'h0000;
   end

   // Chain FSM with registered read data, per-board capture registers and done flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q          <= StScan;
         idx_q            <= 4'h0;
         board_configured <= '0;
         board_base       <= '0;
         data_out         <= 16'h0000;
         autoconfig_done  <= 1'b0;
      end else begin
         data_out <= rd_data;
         unique case (state_q)
            StScan: begin
               if (eligible) begin
                  state_q <= StPresent;
               end else if (idx_q >= LastIdx) begin
                  // Saturate at the end of the chain rather than wrapping back to board 0.
                  idx_q           <= EndIdx;
                  state_q         <= StDone;
                  autoconfig_done <= 1'b1;
               end else begin
                  idx_q <= idx_q + 4'h1;
               end
            end
            StPresent: begin
               if (wr_base) begin
                  for (int i = 0; i < int'(NUM_BOARDS); i++) begin
                     if (idx_q == 4'(i)) begin
                        board_base[16*i +: 16] <= cur_z3 ? data_in : {data_in[15:8], 8'h00};
                        board_configured[i]    <= 1'b1;
                     end
                  end
                  idx_q   <= idx_q + 4'h1;
                  state_q <= StScan;
               end
`ifdef MINIMIG_AUTOCONFIG_SHUTUP_EN
               else if (bus_wr && (address_in == AddrShutup)) begin
                  // Skip this board: it stays unconfigured and keeps its old base.
                  idx_q   <= idx_q + 4'h1;
                  state_q <= StScan;
               end
`endif
            end
            StDone: begin
               autoconfig_done <= 1'b1;
            end
            default: begin
               state_q <= StScan;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_minimig_autoconfig_chain.sv
// Directed bench for minimig_autoconfig_chain (NUM_BOARDS=4, MANUFACTURER=16'h0A1C).
module tb_minimig_autoconfig_chain;

   logic        clk;
   logic        reset;
   logic        clk7_en;
   logic [7:0]  address_in;
   logic [15:0] data_in;
   logic        rd;
   logic        hwr;
   logic        lwr;
   logic        sel;
   logic        m68020;
   logic [3:0]  board_enable;
   logic [3:0]  board_z3;
   logic [15:0] board_size;
   logic [15:0] data_out;
   logic [3:0]  board_configured;
   logic [63:0] board_base;
   logic        autoconfig_done;

   int errors = 0;
   int checks = 0;

   minimig_autoconfig_chain #(
      .NUM_BOARDS   (4),
      .MANUFACTURER (16'h0A1C)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .clk7_en          (clk7_en),
      .address_in       (address_in),
      .data_in          (data_in),
      .rd               (rd),
      .hwr              (hwr),
      .lwr              (lwr),
      .sel              (sel),
      .m68020           (m68020),
      .board_enable     (board_enable),
      .board_z3         (board_z3),
      .board_size       (board_size),
      .data_out         (data_out),
      .board_configured (board_configured),
      .board_base       (board_base),
      .autoconfig_done  (autoconfig_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sel   = 1'b0;
      hwr   = 1'b0;
      lwr   = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic read(input logic [7:0] addr);
      sel        = 1'b1;
      address_in = addr;
      tick();
   endtask

   task automatic write(input logic [7:0] addr, input logic [15:0] data);
      sel        = 1'b1;
      address_in = addr;
      data_in    = data;
      hwr        = 1'b1;
      tick();
      hwr        = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      clk7_en      = 1'b1;
      address_in   = 8'h00;
      data_in      = 16'h0000;
      rd           = 1'b0;
      hwr          = 1'b0;
      lwr          = 1'b0;
      sel          = 1'b0;
      m68020       = 1'b0;
      board_enable = 4'b0101;
      board_z3     = 4'b0000;
      board_size   = 16'h0306;

      // Two Zorro II boards at positions 0 and 2.
      do_reset();
      check("rst_data_out", 64'(data_out), 64'h0);
      check("rst_configured", 64'(board_configured), 64'h0);
      check("rst_base", board_base, 64'h0);
      check("rst_done", 64'(autoconfig_done), 64'h0);
      tick();
      read(8'h01);
      check("a_size0", 64'(data_out), 64'h6FFF);
      read(8'h00);
      check("a_type0", 64'(data_out), 64'hEFFF);
      read(8'h08);
      check("a_mfg_0x10", 64'(data_out), 64'hFFFF);
      read(8'h09);
      check("a_mfg_0x12", 64'(data_out), 64'h5FFF);
      read(8'h0B);
      check("a_mfg_0x16", 64'(data_out), 64'h3FFF);
      write(8'h24, 16'h2000);
      check("a_base0", board_base, 64'h0000_0000_0000_2000);
      check("a_cfg0", 64'(board_configured), 64'h1);
      read(8'h03);
      read(8'h03);
      read(8'h03);
      check("a_product2", 64'(data_out), 64'hDFFF);
      read(8'h01);
      check("a_size2", 64'(data_out), 64'h3FFF);
      check("a_not_done", 64'(autoconfig_done), 64'h0);
      write(8'h24, 16'h4455);
      tick();
      check("a_done", 64'(autoconfig_done), 64'h1);
      check("a_cfg_all", 64'(board_configured), 64'h5);
      check("a_base_all", board_base, 64'h0000_4400_0000_2000);
      write(8'h24, 16'hFFFF);
      check("a_done_wr_ignored", board_base, 64'h0000_4400_0000_2000);
      read(8'h00);
      check("a_done_read", 64'(data_out), 64'hFFFF);

      // Only a Zorro III board on a 68000: nothing eligible.
      board_enable = 4'b0010;
      board_z3     = 4'b0010;
      m68020       = 1'b0;
      do_reset();
      check("b_done_at_release", 64'(autoconfig_done), 64'h0);
      for (int i = 0; i < 5; i++) tick();
      check("b_done", 64'(autoconfig_done), 64'h1);
      check("b_cfg", 64'(board_configured), 64'h0);
      read(8'h00);
      check("b_read", 64'(data_out), 64'hFFFF);

      // Zorro III board 0 with a 68020.
      board_enable = 4'b0001;
      board_z3     = 4'b0001;
      m68020       = 1'b1;
      do_reset();
      tick();
      read(8'h00);
      check("c_type_z3", 64'(data_out), 64'hAFFF);
      write(8'h24, 16'h1234);
      check("c_z2_wr_ignored", 64'(board_configured), 64'h0);
      read(8'h00);
      check("c_still_present", 64'(data_out), 64'hAFFF);
      clk7_en = 1'b0;
      write(8'h22, 16'h4000);
      clk7_en = 1'b1;
      check("c_no_clk7_ignored", 64'(board_configured), 64'h0);
      write(8'h22, 16'h4000);
      check("c_base_z3", board_base, 64'h0000_0000_0000_4000);
      check("c_cfg_z3", 64'(board_configured), 64'h1);

      // Reset while board 1 is presented after board 0 was configured.
      board_enable = 4'b0011;
      board_z3     = 4'b0000;
      m68020       = 1'b0;
      do_reset();
      tick();
      write(8'h24, 16'h8000);
      check("d_cfg0", 64'(board_configured), 64'h1);
      read(8'h03);
      read(8'h03);
      check("d_product1", 64'(data_out), 64'hEFFF);
      reset = 1'b1;
      tick();
      check("d_rst_data_out", 64'(data_out), 64'h0);
      check("d_rst_cfg", 64'(board_configured), 64'h0);
      check("d_rst_base", board_base, 64'h0);
      check("d_rst_done", 64'(autoconfig_done), 64'h0);
      reset = 1'b0;
      tick();
      read(8'h03);
      check("d_rescan_product0", 64'(data_out), 64'hFFFF);
      read(8'h00);
      check("d_rescan_type0", 64'(data_out), 64'hEFFF);
      sel        = 1'b0;
      address_in = 8'h08;
      tick();
      check("d_sel0", 64'(data_out), 64'h0000);

      // Shut-up register on board 0.
      write(8'h26, 16'h0000);
      check("e_shutup_cfg", 64'(board_configured), 64'h0);
`ifdef MINIMIG_AUTOCONFIG_SHUTUP_EN
      read(8'h03);
      read(8'h03);
      check("e_shutup_next", 64'(data_out), 64'hEFFF);
`else
      read(8'h03);
      check("e_shutup_stay_product", 64'(data_out), 64'hFFFF);
      read(8'h00);
      check("e_shutup_stay_type", 64'(data_out), 64'hEFFF);
`endif

      // Write and board_enable drop in the same clock: the write still lands.
      board_enable = 4'b0000;
      write(8'h24, 16'h9000);
`ifdef MINIMIG_AUTOCONFIG_SHUTUP_EN
      check("f_wr_wins", 64'(board_configured), 64'h2);
`else
      check("f_wr_wins", 64'(board_configured), 64'h1);
`endif
      for (int i = 0; i < 5; i++) tick();
      check("f_done", 64'(autoconfig_done), 64'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
